// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cache_pkg;

   // Controller FSM encoding, kept as plain constants for legacy tools.
   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] RD_MISS = 2'd1;
   localparam logic [STATE_W-1:0] WR_THRU = 2'd2;

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid bits, tag store and line store indexed by set.
// Latency: reads are combinational, writes land on the next clk edge.
// Backpressure: none; the controller sequences every write.
module cache_way_array #(
   parameter int INDEX_W    = 6,
   parameter int TAG_W      = 10,
   parameter int LINE_W     = 64,
   parameter int DATA_W     = 32,
   parameter int WORD_SEL_W = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_W-1:0]    index,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [LINE_W-1:0]     rd_line,
   input  logic                  clear,
   input  logic                  line_we,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [LINE_W-1:0]     wr_line,
   input  logic                  word_we,
   input  logic [WORD_SEL_W-1:0] word_sel,
   input  logic [DATA_W-1:0]     wr_word
);

   localparam int SETS = 2 ** INDEX_W;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [LINE_W-1:0] line_mem [SETS];

   assign rd_valid = valid_q[index];
   assign rd_tag   = tag_mem[index];
   assign rd_line  = line_mem[index];

   // Valid bits: cleared by reset or flush, set when a whole line is filled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clear) begin
         valid_q <= '0;
      end else if (line_we) begin
         valid_q[index] <= 1'b1;
      end
   end

   // Tag/line storage: full-line fill on a miss, single-word patch on a store hit.
   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_mem[index]  <= wr_tag;
         line_mem[index] <= wr_line;
      end else if (word_we) begin
         line_mem[index][word_sel*DATA_W +: DATA_W] <= wr_word;
      end
   end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way set-associative write-through, read-allocate cache between MEM stage and SRAM.
// Latency: load hit completes in the request cycle; misses and stores finish on sram_ready.
// Backpressure: ready stays low (MEM stage frozen) until the SRAM transaction completes.
module assoc_cache_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LINE_W  = 64,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 10,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic              flush,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_address,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_write,
   output logic              sram_read,
   input  logic [LINE_W-1:0] sram_rdata,
   input  logic              sram_ready,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   import cache_pkg::*;

   localparam int OFF_W      = $clog2(LINE_W / 8);
   localparam int WORD_LSB   = $clog2(DATA_W / 8);
   localparam int WORD_SEL_W = OFF_W - WORD_LSB;
   localparam int SETS       = 2 ** INDEX_W;

   logic [INDEX_W-1:0]    set_idx;
   logic [TAG_W-1:0]      addr_tag;
   logic [WORD_SEL_W-1:0] word_sel;

   logic [STATE_W-1:0] state_q, state_d;
   logic [SETS-1:0]    lru_q;

   logic [1:0]        way_valid, way_hit, way_line_we, way_word_we;
   logic [TAG_W-1:0]  way_tag  [2];
   logic [LINE_W-1:0] way_line [2];

   logic              hit, hit_way, victim;
   logic [LINE_W-1:0] hit_line;
   logic              flush_clr, lru_we, lru_d, hit_inc, miss_inc;

   assign set_idx      = address[OFF_W +: INDEX_W];
   assign addr_tag     = address[OFF_W+INDEX_W +: TAG_W];
   assign word_sel     = address[WORD_LSB +: WORD_SEL_W];
   assign sram_address = address;
   assign sram_wdata   = wdata;

   for (genvar w = 0; w < 2; w++) begin : g_way
      cache_way_array #(
         .INDEX_W    (INDEX_W),
         .TAG_W      (TAG_W),
         .LINE_W     (LINE_W),
         .DATA_W     (DATA_W),
         .WORD_SEL_W (WORD_SEL_W)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .index    (set_idx),
         .rd_valid (way_valid[w]),
         .rd_tag   (way_tag[w]),
         .rd_line  (way_line[w]),
         .clear    (flush_clr),
         .line_we  (way_line_we[w]),
         .wr_tag   (addr_tag),
         .wr_line  (sram_rdata),
         .word_we  (way_word_we[w]),
         .word_sel (word_sel),
         .wr_word  (wdata)
      );
      assign way_hit[w] = way_valid[w] && (way_tag[w] == addr_tag);
   end

   assign hit      = |way_hit;
   assign hit_way  = way_hit[1];
   assign hit_line = way_hit[0] ? way_line[0] : way_line[1];
   // Fill an empty way first (way 0 preferred); otherwise evict the LRU way.
   assign victim   = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru_q[set_idx]);

   // FSM next state and handshake outputs; everything is held quiet while rst is high.
   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      sram_read   = 1'b0;
      sram_write  = 1'b0;
      rdata       = '0;
      way_line_we = '0;
      way_word_we = '0;
      flush_clr   = 1'b0;
      lru_we      = 1'b0;
      lru_d       = 1'b0;
      hit_inc     = 1'b0;
      miss_inc    = 1'b0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  flush_clr = 1'b1;
               end else if (MEM_W_EN) begin
                  sram_write = 1'b1;
                  state_d    = WR_THRU;
               end else if (MEM_R_EN) begin
                  if (hit) begin
                     ready   = 1'b1;
                     rdata   = hit_line[word_sel*DATA_W +: DATA_W];
                     lru_we  = 1'b1;
                     lru_d   = ~hit_way;
                     hit_inc = 1'b1;
                  end else begin
                     sram_read = 1'b1;
                     state_d   = RD_MISS;
                  end
               end
            end
            RD_MISS: begin
               sram_read = 1'b1;
               if (sram_ready) begin
                  way_line_we[victim] = 1'b1;
                  lru_we   = 1'b1;
                  lru_d    = ~victim;
                  rdata    = sram_rdata[word_sel*DATA_W +: DATA_W];
                  ready    = 1'b1;
                  miss_inc = 1'b1;
                  state_d  = IDLE;
               end
            end
            WR_THRU: begin
               sram_write = 1'b1;
               if (sram_ready) begin
                  ready   = 1'b1;
                  state_d = IDLE;
                  if (hit) begin
                     way_word_we[hit_way] = 1'b1;
                     lru_we = 1'b1;
                     lru_d  = ~hit_way;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM state and per-set LRU bits (LRU bit names the way to evict next).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         lru_q   <= '0;
      end else begin
         state_q <= state_d;
         if (flush_clr) begin
            lru_q <= '0;
         end else if (lru_we) begin
            lru_q[set_idx] <= lru_d;
         end
      end
   end

   // Saturating load hit/miss counters for profiling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit_inc && (hit_count != {CNT_W{1'b1}})) begin
            hit_count <= hit_count + CNT_W'(1);
         end
         if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
            miss_count <= miss_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl with a hand-driven SRAM handshake.
// Latency: n/a.
// Backpressure: n/a.
module tb_assoc_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] address, wdata;
   logic        MEM_R_EN, MEM_W_EN, flush;
   logic [31:0] rdata;
   logic        ready;
   logic [31:0] sram_address, sram_wdata;
   logic        sram_write, sram_read;
   logic [63:0] sram_rdata;
   logic        sram_ready;
   logic [31:0] hit_count, miss_count;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assoc_cache_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .wdata        (wdata),
      .MEM_R_EN     (MEM_R_EN),
      .MEM_W_EN     (MEM_W_EN),
      .flush        (flush),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_write   (sram_write),
      .sram_read    (sram_read),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Load that misses: request, one held cycle, then SRAM returns the line.
   task automatic do_miss(input string tag, input logic [31:0] a, input logic [63:0] line,
                          input logic [31:0] exp_word, input logic [31:0] exp_miss);
      address  = a;
      MEM_R_EN = 1'b1;
      #1;
      check({tag, ".sram_read"}, 64'(sram_read), 64'd1);
      check({tag, ".ready_lo"}, 64'(ready), 64'd0);
      @(negedge clk);
      check({tag, ".read_held"}, 64'(sram_read), 64'd1);
      check({tag, ".wait_lo"}, 64'(ready), 64'd0);
      sram_rdata = line;
      sram_ready = 1'b1;
      #1;
      check({tag, ".ready"}, 64'(ready), 64'd1);
      check({tag, ".rdata"}, 64'(rdata), 64'(exp_word));
      check({tag, ".sram_addr"}, 64'(sram_address), 64'(a));
      @(negedge clk);
      sram_ready = 1'b0;
      sram_rdata = '0;
      MEM_R_EN   = 1'b0;
      #1;
      check({tag, ".miss_cnt"}, 64'(miss_count), 64'(exp_miss));
      check({tag, ".read_done"}, 64'(sram_read), 64'd0);
   endtask

   // Load that hits: ready in the request cycle, no SRAM traffic.
   task automatic do_hit(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_word, input logic [31:0] exp_hit);
      address  = a;
      MEM_R_EN = 1'b1;
      #1;
      check({tag, ".ready"}, 64'(ready), 64'd1);
      check({tag, ".rdata"}, 64'(rdata), 64'(exp_word));
      check({tag, ".no_read"}, 64'(sram_read), 64'd0);
      @(negedge clk);
      MEM_R_EN = 1'b0;
      #1;
      check({tag, ".hit_cnt"}, 64'(hit_count), 64'(exp_hit));
   endtask

   // Store: write-through, sram_write held until sram_ready; optional simultaneous read.
   task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic also_read);
      address  = a;
      wdata    = d;
      MEM_W_EN = 1'b1;
      MEM_R_EN = also_read;
      #1;
      check({tag, ".sram_write"}, 64'(sram_write), 64'd1);
      check({tag, ".no_read"}, 64'(sram_read), 64'd0);
      check({tag, ".ready_lo"}, 64'(ready), 64'd0);
      check({tag, ".sram_wdata"}, 64'(sram_wdata), 64'(d));
      @(negedge clk);
      check({tag, ".write_held"}, 64'(sram_write), 64'd1);
      sram_ready = 1'b1;
      #1;
      check({tag, ".ready"}, 64'(ready), 64'd1);
      @(negedge clk);
      sram_ready = 1'b0;
      MEM_W_EN   = 1'b0;
      MEM_R_EN   = 1'b0;
      #1;
      check({tag, ".write_done"}, 64'(sram_write), 64'd0);
   endtask

   initial begin
      rst        = 1'b1;
      address    = '0;
      wdata      = '0;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      flush      = 1'b0;
      sram_rdata = '0;
      sram_ready = 1'b0;
      #12;
      check("rst.ready", 64'(ready), 64'd0);
      check("rst.sram_read", 64'(sram_read), 64'd0);
      check("rst.sram_write", 64'(sram_write), 64'd0);
      check("rst.rdata", 64'(rdata), 64'd0);
      check("rst.hit_cnt", 64'(hit_count), 64'd0);
      check("rst.miss_cnt", 64'(miss_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Set 8 holds tags 0 (0x040), 1 (0x240), 2 (0x440), 4 (0x840).
      do_miss("ld040", 32'h0000_0040, 64'h1111_2222_3333_4444, 32'h3333_4444, 32'd1);
      do_hit("ld044", 32'h0000_0044, 32'h1111_2222, 32'd1);
      do_hit("ld040h", 32'h0000_0040, 32'h3333_4444, 32'd2);
      do_miss("ld240", 32'h0000_0240, 64'h5555_6666_7777_8888, 32'h7777_8888, 32'd2);
      // Both ways valid, LRU points at way 0 (0x040): it is evicted.
      do_miss("ld440", 32'h0000_0440, 64'h9999_AAAA_BBBB_CCCC, 32'hBBBB_CCCC, 32'd3);
      do_store("st240", 32'h0000_0240, 32'hDEAD_BEEF, 1'b0);
      do_hit("ld240h", 32'h0000_0240, 32'hDEAD_BEEF, 32'd3);
      do_hit("ld244h", 32'h0000_0244, 32'h5555_6666, 32'd4);
      // 0x040 was evicted; this refill replaces way 0 (0x440), the LRU way now.
      do_miss("re040", 32'h0000_0040, 64'h0102_0304_0506_0708, 32'h0506_0708, 32'd4);
      // Store miss with both enables: write wins, cache untouched, no count.
      do_store("st840", 32'h0000_0840, 32'hCAFE_F00D, 1'b1);
      check("st840.hit_cnt", 64'(hit_count), 64'd4);
      do_miss("ld840", 32'h0000_0840, 64'h0BAD_0BAD_0840_0840, 32'h0840_0840, 32'd5);
      check("preflush.hit_cnt", 64'(hit_count), 64'd4);

      // Flush with a would-be hit pending: no ready that cycle, miss the next.
      flush    = 1'b1;
      address  = 32'h0000_0044;
      MEM_R_EN = 1'b1;
      #1;
      check("flush.ready_lo", 64'(ready), 64'd0);
      check("flush.no_read", 64'(sram_read), 64'd0);
      @(negedge clk);
      flush = 1'b0;
      do_miss("postflush044", 32'h0000_0044, 64'h1111_2222_3333_4444, 32'h1111_2222, 32'd6);
      check("postflush.hit_cnt", 64'(hit_count), 64'd4);

      // Reset in the middle of a miss: request abandoned, nothing filled.
      address  = 32'h0000_0048;
      MEM_R_EN = 1'b1;
      @(negedge clk);
      check("rstmiss.read", 64'(sram_read), 64'd1);
      rst = 1'b1;
      #1;
      check("rstmiss.read_drop", 64'(sram_read), 64'd0);
      check("rstmiss.ready", 64'(ready), 64'd0);
      check("rstmiss.miss_cnt", 64'(miss_count), 64'd0);
      check("rstmiss.hit_cnt", 64'(hit_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmiss.rereq", 64'(sram_read), 64'd1);
      do_miss("ld048", 32'h0000_0048, 64'hFEED_FACE_0048_0048, 32'h0048_0048, 32'd1);
      do_hit("ld04c", 32'h0000_004C, 32'hFEED_FACE, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
